x86_decoder: RTL and testbench
==============================

X86_DECODER -- requirements
Module: x86_decoder

Interface
REQ-001 Parameter MAX_PREFIX, default 4: maximum number of legacy prefix bytes accepted before the instruction is flagged illegal.
REQ-002 clk  in  1  system clock (bus.clk); all registered outputs update on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset (bus.reset).
REQ-004 in_valid  in  1  window holds at least 15 fetched bytes (core can_decode).
REQ-005 in_bytes  in  120  15-byte window; byte 0 occupies the most-significant 8 bits, byte k the next lower 8 bits after byte k-1.
REQ-006 len  out  4  combinational instruction length 1-15; 0 when not decodable.
REQ-007 illegal  out  1  combinational; in_valid high and the window start is not a supported instruction.
REQ-008 dec_valid  out  1  registered pulse for one decoded instruction.
REQ-009 dec_len  out  4  registered length.
REQ-010 dec_opcode  out  9  registered {escape_0F, opcode byte}.
REQ-011 dec_rex  out  4  registered REX W,R,X,B bits; 0 if no REX.
REQ-012 dec_prefix  out  4  registered flags {lock F0, rep F3, repne F2, opsize 66}.
REQ-013 dec_modrm  out  9  registered {present, ModRM byte}.
REQ-014 dec_disp  out  32  registered displacement, sign-extended; 0 if none.
REQ-015 dec_imm  out  64  registered immediate; imm8/16/32 sign-extended, imm64 raw little-endian; 0 if none.

Function
REQ-016 Multi-byte fields are little-endian.
REQ-017 Prefix scan:
- bytes 66, 67, F0, F2, F3, 26, 2E, 36, 3E, 64, 65 are prefixes;
- more than MAX_PREFIX prefixes makes the instruction illegal.
REQ-018 A byte 40-4F directly after the prefixes is REX. A REX not immediately before the opcode is ignored: only the last REX counts.
REQ-019 Opcode 0F selects the two-byte map; the following byte is the opcode.
REQ-020 Immediate "iz" is 4 bytes, or 2 bytes when 66 is present.
REQ-021 One-byte map, ModRM only:
- 00-3F (excluding prefix bytes and 27/2F/37/3F) with low 3 bits 0-3;
- 63; 84-8F; D0-D3; FE; FF.
REQ-022 One-byte map, no ModRM:
- 00-3F group with low 3 bits 4 -> imm8, low 3 bits 5 -> iz;
- 50-5F, 90-99, C3, C9, CC, F4 -> no immediate;
- 68 -> iz; 6A -> imm8; 70-7F -> imm8; EB -> imm8; E8, E9 -> imm32;
- A8 -> imm8; A9 -> iz; B0-B7 -> imm8; B8-BF -> iz, or imm64 when REX.W;
- C2 -> imm16.
REQ-023 One-byte map, ModRM plus immediate:
- imm8: 6B, 80, 83, C0, C1, C6;
- iz: 69, 81, C7;
- F6 adds imm8 and F7 adds iz only when ModRM.reg is 0 or 1.
REQ-024 Two-byte map:
- 05 syscall and A2 cpuid: no operands;
- 1F, 40-4F, 90-9F, AF, B6, B7, BE, BF: ModRM;
- 80-8F: imm32.
REQ-025 Every opcode not listed in REQ-021 to REQ-024 is illegal.
REQ-026 ModRM addressing:
- mod=3: no SIB and no displacement;
- otherwise rm=4 adds a SIB byte;
- mod=1 adds disp8 and mod=2 adds disp32;
- mod=0 with rm=5 adds disp32 (RIP-relative);
- mod=0 with a SIB whose base is 5 adds disp32.
REQ-027 len = prefixes + REX + opcode bytes + ModRM + SIB + displacement + immediate.
REQ-028 A computed length above 15 is illegal.
REQ-029 When in_valid is 0, or illegal is 1: len=0.
REQ-030 len and illegal are purely combinational from in_valid and in_bytes (same cycle). The core adds len to its decode offset.
REQ-031 On each rising edge with in_valid=1 and illegal=0:
- dec_valid=1;
- all dec_* fields load the current decode (1-cycle latency).
REQ-032 On any other edge, dec_valid=0 and the dec_* fields hold their previous values.
REQ-033 Back-to-back instructions decode at one per cycle with no bubbles.

Reset
REQ-034 While reset=1, asynchronously and independent of clk: dec_valid=0 and all dec_* fields are 0.
REQ-035 The first capture after reset deasserts occurs at the first rising edge with reset=0 and a legal in_valid window.
REQ-036 Reset asserted mid-stream discards the pending capture with no partial update.

Verification
REQ-037 48 89 E5 -> len=3; next edge: dec_rex=1000, dec_opcode=0_89, dec_modrm=1_E5.
REQ-038 48 B8 EF CD AB 89 67 45 23 01 -> len=10, dec_imm=0123456789ABCDEF.
REQ-039 8B 44 24 F8 -> len=4 (SIB + disp8), dec_disp=FFFFFFF8.
REQ-040 66 81 C3 34 12 -> len=5, dec_prefix opsize=1, dec_imm=1234. Same bytes without 66, i.e. 81 C3 78 56 34 12 -> len=6.
REQ-041 Branch and RIP-relative: E8 rel32 -> len=5; 0F 84 rel32 -> len=6; 8B 05 disp32 -> len=6.
REQ-042 Illegal and reset cases:
- 06 -> illegal=1, len=0, dec_valid stays 0;
- five 66 prefixes -> illegal;
- in_valid=0 -> len=0;
- reset pulse between edges -> dec_* cleared immediately.

Source files
------------

// File: rtl/x86_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | x86_decoder                                                              |
// | Single-cycle x86-64 length decoder over a 15-byte fetch window with a    |
// | registered field capture.                                                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module x86_decoder #(
  parameter int MAX_PREFIX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [119:0] in_bytes,
  output logic [3:0]   len,
  output logic         illegal,
  output logic         dec_valid,
  output logic [3:0]   dec_len,
  output logic [8:0]   dec_opcode,
  output logic [3:0]   dec_rex,
  output logic [3:0]   dec_prefix,
  output logic [8:0]   dec_modrm,
  output logic [31:0]  dec_disp,
  output logic [63:0]  dec_imm
);

  // Bytes past the window read as zero; any decode reaching them overflows 15.
  function automatic logic [7:0] byte_at(input logic [119:0] win, input int k);
    logic [6:0] idx;
    byte_at = 8'h00;
    idx     = 7'd0;
    if (k >= 0 && k < 15) begin
      idx     = 7'(8 * (14 - k));
      byte_at = win[idx +: 8];
    end
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    case (b)
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: is_prefix = 1'b1;
      default:                                   is_prefix = 1'b0;
    endcase
  endfunction

  int          w_pos, w_npfx, w_q, w_izs, w_isz, w_dsz, w_dpos, w_ipos, w_total;
  logic        w_scan, w_esc, w_ok, w_has_m, w_sib, w_sib_base5, w_illegal;
  logic [7:0]  w_b, w_op, w_modrm;
  logic [3:0]  w_rex, w_pfx;
  logic [31:0] w_disp;
  logic [63:0] w_raw, w_imm;

  logic        r_valid;
  logic [3:0]  r_len, r_rex, r_pfx;
  logic [8:0]  r_opcode, r_modrm;
  logic [31:0] r_disp;
  logic [63:0] r_imm;

  // A prefix after a REX cancels it, so only a REX adjacent to the opcode survives.
  always_comb begin
    w_pos  = 0;
    w_npfx = 0;
    w_rex  = 4'h0;
    w_pfx  = 4'h0;
    w_scan = 1'b1;
    w_b    = 8'h00;
    for (int k = 0; k < 15; k++) begin
      w_b = byte_at(in_bytes, k);
      if (w_scan) begin
        if (is_prefix(w_b)) begin
          w_npfx = w_npfx + 1;
          w_rex  = 4'h0;
          w_pos  = k + 1;
          case (w_b)
            8'hF0:   w_pfx[3] = 1'b1;
            8'hF3:   w_pfx[2] = 1'b1;
            8'hF2:   w_pfx[1] = 1'b1;
            8'h66:   w_pfx[0] = 1'b1;
            default: ;
          endcase
        end else if (w_b[7:4] == 4'h4) begin
          w_rex = w_b[3:0];
          w_pos = k + 1;
        end else begin
          w_scan = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_esc   = (byte_at(in_bytes, w_pos) == 8'h0F);
    w_op    = w_esc ? byte_at(in_bytes, w_pos + 1) : byte_at(in_bytes, w_pos);
    w_q     = w_pos + (w_esc ? 2 : 1);
    w_modrm = byte_at(in_bytes, w_q);
    w_izs   = w_pfx[0] ? 2 : 4;
    w_ok    = 1'b1;
    w_has_m = 1'b0;
    w_isz   = 0;
    if (w_esc) begin
      case (w_op) inside
        8'h05, 8'hA2: ;
        8'h1F, [8'h40:8'h4F], [8'h90:8'h9F], 8'hAF, 8'hB6, 8'hB7, 8'hBE, 8'hBF:
          w_has_m = 1'b1;
        [8'h80:8'h8F]: w_isz = 4;
        default: w_ok = 1'b0;
      endcase
    end else begin
      case (w_op) inside
        [8'h00:8'h3F]: begin
          if (w_op[2:0] <= 3'd3)      w_has_m = 1'b1;
          else if (w_op[2:0] == 3'd4) w_isz   = 1;
          else if (w_op[2:0] == 3'd5) w_isz   = w_izs;
          else                        w_ok    = 1'b0;
        end
        8'h63, [8'h84:8'h8F], [8'hD0:8'hD3], 8'hFE, 8'hFF: w_has_m = 1'b1;
        [8'h50:8'h5F], [8'h90:8'h99], 8'hC3, 8'hC9, 8'hCC, 8'hF4: ;
        8'h68, 8'hA9: w_isz = w_izs;
        8'h6A, [8'h70:8'h7F], 8'hEB, 8'hA8, [8'hB0:8'hB7]: w_isz = 1;
        8'hE8, 8'hE9: w_isz = 4;
        [8'hB8:8'hBF]: w_isz = w_rex[3] ? 8 : w_izs;
        8'hC2: w_isz = 2;
        8'h6B, 8'h80, 8'h83, 8'hC0, 8'hC1, 8'hC6: begin
          w_has_m = 1'b1;
          w_isz   = 1;
        end
        8'h69, 8'h81, 8'hC7: begin
          w_has_m = 1'b1;
          w_isz   = w_izs;
        end
        8'hF6: begin
          w_has_m = 1'b1;
          if (w_modrm[5:3] <= 3'd1) w_isz = 1;
        end
        8'hF7: begin
          w_has_m = 1'b1;
          if (w_modrm[5:3] <= 3'd1) w_isz = w_izs;
        end
        default: w_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_sib       = w_has_m && (w_modrm[7:6] != 2'b11) && (w_modrm[2:0] == 3'd4);
    w_sib_base5 = ((byte_at(in_bytes, w_q + 1) & 8'h07) == 8'h05);
    w_dsz       = 0;
    if (w_has_m) begin
      case (w_modrm[7:6])
        2'b01:   w_dsz = 1;
        2'b10:   w_dsz = 4;
        2'b00:   if (w_modrm[2:0] == 3'd5 || (w_sib && w_sib_base5)) w_dsz = 4;
        default: ;
      endcase
    end
    w_dpos    = w_q + (w_has_m ? 1 : 0) + (w_sib ? 1 : 0);
    w_ipos    = w_dpos + w_dsz;
    w_total   = w_ipos + w_isz;
    w_illegal = in_valid && (!w_ok || (w_npfx > MAX_PREFIX) || (w_total > 15));
    len       = (in_valid && !w_illegal) ? 4'(w_total) : 4'd0;
    illegal   = w_illegal;
  end

  always_comb begin
    case (w_dsz)
      1:       w_disp = {{24{byte_at(in_bytes, w_dpos) >= 8'h80}}, byte_at(in_bytes, w_dpos)};
      4:       w_disp = {byte_at(in_bytes, w_dpos + 3), byte_at(in_bytes, w_dpos + 2),
                         byte_at(in_bytes, w_dpos + 1), byte_at(in_bytes, w_dpos)};
      default: w_disp = 32'h0;
    endcase
    w_raw = 64'h0;
    for (int j = 0; j < 8; j++) begin
      w_raw[8*j +: 8] = byte_at(in_bytes, w_ipos + j);
    end
    case (w_isz)
      1:       w_imm = {{56{w_raw[7]}},  w_raw[7:0]};
      2:       w_imm = {{48{w_raw[15]}}, w_raw[15:0]};
      4:       w_imm = {{32{w_raw[31]}}, w_raw[31:0]};
      8:       w_imm = w_raw;
      default: w_imm = 64'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_len    <= 4'h0;
      r_opcode <= 9'h0;
      r_rex    <= 4'h0;
      r_pfx    <= 4'h0;
      r_modrm  <= 9'h0;
      r_disp   <= 32'h0;
      r_imm    <= 64'h0;
    end else begin
      r_valid <= 1'b0;
      if (in_valid && !w_illegal) begin
        r_valid  <= 1'b1;
        r_len    <= len;
        r_opcode <= {w_esc, w_op};
        r_rex    <= w_rex;
        r_pfx    <= w_pfx;
        r_modrm  <= w_has_m ? {1'b1, w_modrm} : 9'h0;
        r_disp   <= w_disp;
        r_imm    <= w_imm;
      end
    end
  end

  assign dec_valid  = r_valid;
  assign dec_len    = r_len;
  assign dec_opcode = r_opcode;
  assign dec_rex    = r_rex;
  assign dec_prefix = r_pfx;
  assign dec_modrm  = r_modrm;
  assign dec_disp   = r_disp;
  assign dec_imm    = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_x86_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_x86_decoder                                                           |
// | Directed-vector bench for the x86 length/field decoder.                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_x86_decoder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [119:0] in_bytes = '0;
  logic [3:0]   len;
  logic         illegal;
  logic         dec_valid;
  logic [3:0]   dec_len;
  logic [8:0]   dec_opcode;
  logic [3:0]   dec_rex;
  logic [3:0]   dec_prefix;
  logic [8:0]   dec_modrm;
  logic [31:0]  dec_disp;
  logic [63:0]  dec_imm;

  int checks = 0;
  int failures = 0;

  x86_decoder #(.MAX_PREFIX(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bytes(in_bytes),
    .len(len), .illegal(illegal), .dec_valid(dec_valid), .dec_len(dec_len),
    .dec_opcode(dec_opcode), .dec_rex(dec_rex), .dec_prefix(dec_prefix),
    .dec_modrm(dec_modrm), .dec_disp(dec_disp), .dec_imm(dec_imm)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  // Left-align n bytes so the first listed byte is window byte 0.
  task automatic apply(input logic [119:0] v, input int n);
    @(negedge clk);
    in_valid = 1'b1;
    in_bytes = v << (8 * (15 - n));
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({dec_valid, dec_len, dec_opcode, dec_rex, dec_prefix, dec_modrm, dec_disp, dec_imm} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%b len=%h imm=%h exp all zero", dec_valid, dec_len, dec_imm);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_mov_rex;
    apply(120'h4889E5, 3);
    checks++; if (len !== 4'd3 || illegal !== 1'b0) begin failures++; $display("FAIL mov_len got=%0d ill=%b exp=3 ill=0", len, illegal); end
    tick;
    checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL mov_valid got=%b exp=1", dec_valid); end
    checks++; if (dec_rex !== 4'b1000) begin failures++; $display("FAIL mov_rex got=%b exp=1000", dec_rex); end
    checks++; if (dec_opcode !== 9'h089) begin failures++; $display("FAIL mov_opcode got=%h exp=089", dec_opcode); end
    checks++; if (dec_modrm !== 9'h1E5) begin failures++; $display("FAIL mov_modrm got=%h exp=1e5", dec_modrm); end
    checks++; if (dec_len !== 4'd3 || dec_imm !== 64'h0 || dec_disp !== 32'h0) begin failures++; $display("FAIL mov_fields got len=%0d imm=%h disp=%h exp 3/0/0", dec_len, dec_imm, dec_disp); end
  endtask

  task automatic test_imm64;
    apply(120'h48B8EFCDAB8967452301, 10);
    checks++; if (len !== 4'd10) begin failures++; $display("FAIL imm64_len got=%0d exp=10", len); end
    tick;
    checks++; if (dec_imm !== 64'h0123456789ABCDEF) begin failures++; $display("FAIL imm64_val got=%h exp=0123456789abcdef", dec_imm); end
    checks++; if (dec_opcode !== 9'h0B8 || dec_modrm !== 9'h0) begin failures++; $display("FAIL imm64_op got=%h modrm=%h exp=0b8/000", dec_opcode, dec_modrm); end
  endtask

  task automatic test_sib_disp8;
    apply(120'h8B4424F8, 4);
    checks++; if (len !== 4'd4) begin failures++; $display("FAIL sib_len got=%0d exp=4", len); end
    tick;
    checks++; if (dec_disp !== 32'hFFFFFFF8) begin failures++; $display("FAIL sib_disp got=%h exp=fffffff8", dec_disp); end
    checks++; if (dec_modrm !== 9'h144 || dec_rex !== 4'h0) begin failures++; $display("FAIL sib_modrm got=%h rex=%h exp=144/0", dec_modrm, dec_rex); end
  endtask

  task automatic test_opsize;
    apply(120'h6681C33412, 5);
    checks++; if (len !== 4'd5) begin failures++; $display("FAIL opsz_len got=%0d exp=5", len); end
    tick;
    checks++; if (dec_prefix !== 4'b0001 || dec_imm !== 64'h1234) begin failures++; $display("FAIL opsz_fields got pfx=%b imm=%h exp=0001/1234", dec_prefix, dec_imm); end
    apply(120'h81C378563412, 6);
    checks++; if (len !== 4'd6) begin failures++; $display("FAIL noopsz_len got=%0d exp=6", len); end
    tick;
    checks++; if (dec_prefix !== 4'b0000 || dec_imm !== 64'h12345678) begin failures++; $display("FAIL noopsz_fields got pfx=%b imm=%h exp=0000/12345678", dec_prefix, dec_imm); end
    // REX followed by a prefix is discarded.
    apply(120'h4866B83412, 5);
    checks++; if (len !== 4'd5) begin failures++; $display("FAIL stale_rex_len got=%0d exp=5", len); end
    tick;
    checks++; if (dec_rex !== 4'h0 || dec_imm !== 64'h1234) begin failures++; $display("FAIL stale_rex_fields got rex=%h imm=%h exp=0/1234", dec_rex, dec_imm); end
  endtask

  task automatic test_branch_rip;
    apply(120'hE800010000, 5);
    checks++; if (len !== 4'd5) begin failures++; $display("FAIL call_len got=%0d exp=5", len); end
    tick;
    checks++; if (dec_imm !== 64'h100) begin failures++; $display("FAIL call_imm got=%h exp=100", dec_imm); end
    apply(120'h0F84FCFFFFFF, 6);
    checks++; if (len !== 4'd6) begin failures++; $display("FAIL jcc_len got=%0d exp=6", len); end
    tick;
    checks++; if (dec_opcode !== 9'h184 || dec_imm !== 64'hFFFFFFFFFFFFFFFC) begin failures++; $display("FAIL jcc_fields got op=%h imm=%h exp=184/fffffffffffffffc", dec_opcode, dec_imm); end
    apply(120'h8B0510000000, 6);
    checks++; if (len !== 4'd6) begin failures++; $display("FAIL rip_len got=%0d exp=6", len); end
    tick;
    checks++; if (dec_disp !== 32'h10 || dec_modrm !== 9'h105) begin failures++; $display("FAIL rip_fields got disp=%h modrm=%h exp=10/105", dec_disp, dec_modrm); end
  endtask

  task automatic test_group3;
    apply(120'hF7D0, 2);
    checks++; if (len !== 4'd2) begin failures++; $display("FAIL f7_not_len got=%0d exp=2", len); end
    apply(120'hF7C078563412, 6);
    checks++; if (len !== 4'd6) begin failures++; $display("FAIL f7_test_len got=%0d exp=6", len); end
    apply(120'hF6D8, 2);
    checks++; if (len !== 4'd2) begin failures++; $display("FAIL f6_neg_len got=%0d exp=2", len); end
    tick;
    checks++; if (dec_len !== 4'd2 || dec_imm !== 64'h0) begin failures++; $display("FAIL f6_fields got len=%0d imm=%h exp=2/0", dec_len, dec_imm); end
  endtask

  task automatic test_illegal;
    apply(120'h06, 1);
    checks++; if (illegal !== 1'b1 || len !== 4'd0) begin failures++; $display("FAIL op06 got ill=%b len=%0d exp=1/0", illegal, len); end
    tick;
    checks++; if (dec_valid !== 1'b0 || dec_len !== 4'd2) begin failures++; $display("FAIL op06_hold got valid=%b len=%0d exp=0/2", dec_valid, dec_len); end
    apply(120'h666666666690, 6);
    checks++; if (illegal !== 1'b1 || len !== 4'd0) begin failures++; $display("FAIL five_pfx got ill=%b len=%0d exp=1/0", illegal, len); end
    apply(120'h0F0B, 2);
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ud2 got ill=%b exp=1", illegal); end
    apply(120'h6666666690, 5);
    checks++; if (illegal !== 1'b0 || len !== 4'd5) begin failures++; $display("FAIL four_pfx got ill=%b len=%0d exp=0/5", illegal, len); end
    apply(120'hF0F0F0F048C7842411223344556677, 15);
    checks++; if (illegal !== 1'b1 || len !== 4'd0) begin failures++; $display("FAIL len16 got ill=%b len=%0d exp=1/0", illegal, len); end
    apply(120'hF0F0F048C784241122334455667788, 15);
    checks++; if (illegal !== 1'b0 || len !== 4'd15) begin failures++; $display("FAIL len15 got ill=%b len=%0d exp=0/15", illegal, len); end
    tick;
    checks++; if (dec_prefix !== 4'b1000 || dec_disp !== 32'h44332211 || dec_imm !== 64'hFFFFFFFF88776655) begin
      failures++; $display("FAIL len15_fields got pfx=%b disp=%h imm=%h exp=1000/44332211/ffffffff88776655", dec_prefix, dec_disp, dec_imm);
    end
  endtask

  task automatic test_invalid;
    @(negedge clk);
    in_valid = 1'b0;
    in_bytes = 120'h4889E5 << 96;
    #1;
    checks++; if (len !== 4'd0 || illegal !== 1'b0) begin failures++; $display("FAIL invalid_len got len=%0d ill=%b exp=0/0", len, illegal); end
    tick;
    checks++; if (dec_valid !== 1'b0 || dec_len !== 4'd15) begin failures++; $display("FAIL invalid_hold got valid=%b len=%0d exp=0/15", dec_valid, dec_len); end
  endtask

  task automatic test_back_to_back;
    apply(120'h90, 1);
    tick;
    checks++; if (dec_valid !== 1'b1 || dec_opcode !== 9'h090 || dec_len !== 4'd1) begin failures++; $display("FAIL b2b_0 got v=%b op=%h len=%0d exp=1/090/1", dec_valid, dec_opcode, dec_len); end
    apply(120'h50, 1);
    tick;
    checks++; if (dec_valid !== 1'b1 || dec_opcode !== 9'h050) begin failures++; $display("FAIL b2b_1 got v=%b op=%h exp=1/050", dec_valid, dec_opcode); end
    apply(120'h6AFB, 2);
    tick;
    checks++; if (dec_valid !== 1'b1 || dec_len !== 4'd2 || dec_imm !== 64'hFFFFFFFFFFFFFFFB) begin failures++; $display("FAIL b2b_2 got v=%b len=%0d imm=%h exp=1/2/fffffffffffffffb", dec_valid, dec_len, dec_imm); end
  endtask

  task automatic test_reset_mid;
    apply(120'h6A05, 2);
    tick;
    checks++; if (dec_valid !== 1'b1 || dec_imm !== 64'h5) begin failures++; $display("FAIL pre_reset got v=%b imm=%h exp=1/5", dec_valid, dec_imm); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({dec_valid, dec_len, dec_opcode, dec_imm} !== '0) begin failures++; $display("FAIL mid_reset got v=%b len=%0d op=%h imm=%h exp all zero", dec_valid, dec_len, dec_opcode, dec_imm); end
    #1 reset = 1'b0;
    tick;
    checks++; if (dec_valid !== 1'b1 || dec_imm !== 64'h5 || dec_opcode !== 9'h06A) begin failures++; $display("FAIL post_reset got v=%b imm=%h op=%h exp=1/5/06a", dec_valid, dec_imm, dec_opcode); end
  endtask

  initial begin
    test_reset;
    test_mov_rex;
    test_imm64;
    test_sib_disp8;
    test_opsize;
    test_branch_rip;
    test_group3;
    test_illegal;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    @(negedge clk) in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
